muldiv_unit: RTL

//  Iterative RV32M/RV64M multiply/divide unit beside the single-cycle ALU in the EX stage.

---
 rtl/muldiv_unit.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit.
// Operands are converted to magnitudes on accept, processed one bit per cycle
// (shift-add multiply, restoring divide) over XLEN cycles, and the result sign
// is fixed up on the final iteration. Divide-by-zero and signed overflow
// bypass the iteration and complete one cycle after accept.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       Funct3,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] XMIN    = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]      cnt;
    logic [2:0]         op;
    logic               neg_res;
    logic [XLEN-1:0]    dvs;        // multiplicand or divisor magnitude
    logic [2*XLEN-1:0]  acc;        // product, or {remainder, dividend/quotient}
    logic [XLEN-1:0]    res_q;
    logic [TAG_W-1:0]   tag_q;

    logic               accept;
    logic               sgn1, sgn2, neg1, neg2;
    logic [XLEN-1:0]    mag1, mag2;
    logic               special;
    logic [XLEN-1:0]    special_res;
    logic [XLEN:0]      mul_sum;
    logic [XLEN:0]      div_sh;
    logic [XLEN:0]      div_diff;
    logic [2*XLEN-1:0]  acc_nxt;
    logic [2*XLEN-1:0]  prod_fix;
    logic [XLEN-1:0]    final_res;

    // Two's-complement negate used for the final sign fix-up.
    function automatic logic [XLEN-1:0] negate_x(input logic [XLEN-1:0] v);
        return ~v + 1'b1;
    endfunction

    function automatic logic [2*XLEN-1:0] negate_2x(input logic [2*XLEN-1:0] v);
        return ~v + 1'b1;
    endfunction

    // Magnitude of an operand interpreted as signed when is_signed is set.
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic is_signed);
        logic signed [XLEN-1:0] sv;
        sv = v;
        return (is_signed && sv < 0) ? negate_x(v) : v;
    endfunction

    assign result  = res_q;
    assign out_tag = tag_q;

    // Operand decode, signedness and special-case detection for the incoming op.
    always_comb begin
        sgn1 = (Funct3 == 3'b001) || (Funct3 == 3'b010) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
        sgn2 = (Funct3 == 3'b001) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
        neg1 = sgn1 & rs1[XLEN-1];
        neg2 = sgn2 & rs2[XLEN-1];
        mag1 = magnitude(rs1, sgn1);
        mag2 = magnitude(rs2, sgn2);
        accept = in_valid && (state == S_IDLE) && !flush;
        special = 1'b0;
        special_res = '0;
        if (Funct3[2]) begin
            if (rs2 == '0) begin
                special = 1'b1;
                special_res = Funct3[1] ? rs1 : '1;
            end else if (!Funct3[0] && rs1 == XMIN && rs2 == '1) begin
                special = 1'b1;
                special_res = Funct3[1] ? '0 : rs1;
            end
        end
    end

    // One iteration of shift-add multiply or restoring divide, plus final sign fix.
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, dvs} : '0);
        div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff = div_sh - {1'b0, dvs};
        if (op[2]) begin
            if (div_diff[XLEN])
                acc_nxt = {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            else
                acc_nxt = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
            acc_nxt = {mul_sum, acc[XLEN-1:1]};
        end
        prod_fix = neg_res ? negate_2x(acc_nxt) : acc_nxt;
        case (op)
            3'b000:                 final_res = acc_nxt[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_res = neg_res ? negate_x(acc_nxt[XLEN-1:0]) : acc_nxt[XLEN-1:0];
            default:                final_res = neg_res ? negate_x(acc_nxt[2*XLEN-1:XLEN]) : acc_nxt[2*XLEN-1:XLEN];
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake outputs; flush returns to IDLE from anywhere.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (accept) state_nxt = special ? S_DONE : S_CALC;
            end
            S_CALC: begin
                if (flush)             state_nxt = S_IDLE;
                else if (cnt == '0)    state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (flush || out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: latch operands on accept, iterate in CALC, capture the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            op      <= '0;
            neg_res <= 1'b0;
            dvs     <= '0;
            acc     <= '0;
            res_q   <= '0;
            tag_q   <= '0;
        end else if (accept) begin
            op      <= Funct3;
            tag_q   <= in_tag;
            neg_res <= (Funct3 == 3'b110) ? neg1 : (neg1 ^ neg2);
            dvs     <= mag2;
            acc     <= {{XLEN{1'b0}}, mag1};
            cnt     <= CNT_MAX;
            if (special) res_q <= special_res;
        end else if (state == S_CALC && !flush) begin
            acc <= acc_nxt;
            cnt <= cnt - 1'b1;
            if (cnt == '0) res_q <= final_res;
        end
    end

endmodule
